// File: rtl/game_pkg.sv
// game_pkg: shared lane type and keycode constants for the rhythm game.
// Holds the 2-bit lane typedef, the four lane keycodes (7, 9, 13, 14)
// and the space/q menu keycodes (44, 20).
package game_pkg;
  typedef logic [1:0] lane_t;
  localparam logic [7:0] KEY_LANE0 = 8'd7;
  localparam logic [7:0] KEY_LANE1 = 8'd9;
  localparam logic [7:0] KEY_LANE2 = 8'd13;
  localparam logic [7:0] KEY_LANE3 = 8'd14;
  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_Q     = 8'd20;
  function automatic logic is_lane_key(input logic [7:0] k);
    return k == KEY_LANE0 || k == KEY_LANE1 || k == KEY_LANE2 || k == KEY_LANE3;
  endfunction
  function automatic lane_t key_lane(input logic [7:0] k);
    return k == KEY_LANE1 ? 2'd1 : k == KEY_LANE2 ? 2'd2 : k == KEY_LANE3 ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/note_slot.sv
// note_slot: one falling-circle slot (live flag, lane, life timer).
// Ports: clk, rst_n (async active-low), clear (sync wipe), frame_tick,
//   load_i (launch into this idle slot), lane_i, hit_i (scored press retires
//   this slot), live_o, lane_o, timer_o, expire_o (retires unhit this cycle).
module note_slot
  import game_pkg::*;
#(
  parameter int LIFE_TICKS = 120,
  parameter int TW         = $clog2(LIFE_TICKS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          frame_tick,
  input  logic          load_i,
  input  lane_t         lane_i,
  input  logic          hit_i,
  output logic          live_o,
  output lane_t         lane_o,
  output logic [TW-1:0] timer_o,
  output logic          expire_o
);
  logic          live_q, live_d;
  lane_t         lane_q, lane_d;
  logic [TW-1:0] timer_q, timer_d;
  // A hit on the final tick wins over the expiry.
  assign expire_o = live_q & frame_tick & (timer_q == TW'(1)) & ~hit_i & ~clear;
  always_comb begin
    live_d  = (clear | hit_i | expire_o) ? 1'b0 : load_i ? 1'b1 : live_q;
    lane_d  = clear ? 2'd0 : load_i ? lane_i : lane_q;
    timer_d = load_i ? TW'(LIFE_TICKS) : (live_q & frame_tick) ? timer_q - TW'(1) : timer_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      live_q  <= 1'b0;
      lane_q  <= 2'd0;
      timer_q <= '0;
    end else begin
      live_q  <= live_d;
      lane_q  <= lane_d;
      timer_q <= timer_d;
    end
  assign live_o  = live_q;
  assign lane_o  = lane_q;
  assign timer_o = timer_q;
endmodule

// File: rtl/note_tracker.sv
// note_tracker: tracks live circles, scores presses, counts misses and health.
// Ports: clk, rst_n (async active-low), clear, frame_tick, spawn, circletype,
//   keycode (HID, 0 = none); outputs out_of_bounds, hit, miss, spawn_drop
//   (registered one-cycle pulses), health (saturating 0..15), active and
//   slot_lane (per-slot renderer view).
// Optional: define NOTE_TRACKER_SCORE_EN to add a 16-bit saturating hit count
//   on output score.
module note_tracker
  import game_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int LIFE_TICKS  = 120,
  parameter int HIT_WINDOW  = 15,
  parameter int HEALTH_INIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   frame_tick,
  input  logic                   spawn,
  input  logic [1:0]             circletype,
  input  logic [7:0]             keycode,
  output logic                   out_of_bounds,
  output logic                   hit,
  output logic                   miss,
  output logic [3:0]             health,
  output logic [NUM_SLOTS-1:0]   active,
  output logic [2*NUM_SLOTS-1:0] slot_lane,
  output logic                   spawn_drop
`ifdef NOTE_TRACKER_SCORE_EN
  ,
  output logic [15:0]            score
`endif
);
  localparam int TW = $clog2(LIFE_TICKS + 1);
  logic [NUM_SLOTS-1:0] live_w, expire_w, load_w, hit_w;
  lane_t                lane_w  [NUM_SLOTS];
  logic [TW-1:0]        timer_w [NUM_SLOTS];
  logic [7:0]           key_q;
  logic [3:0]           health_q, health_d;
  logic                 hit_q, miss_q, oob_q, drop_q, drop_d, press;
  lane_t                press_lane;
  assign press      = (keycode != key_q) && is_lane_key(keycode);
  assign press_lane = key_lane(keycode);
  // Retiring slots are still live this cycle, so the idle search below can
  // never hand a retiring slot to a new spawn.
  always_comb begin
    logic found_h, found_s;
    int   nm, h;
    hit_w   = '0;
    load_w  = '0;
    found_h = 1'b0;
    found_s = 1'b0;
    nm      = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found_h && press && !clear && live_w[i] && lane_w[i] == press_lane &&
          timer_w[i] <= TW'(HIT_WINDOW)) begin
        hit_w[i] = 1'b1;
        found_h  = 1'b1;
      end
      if (!found_s && spawn && !clear && !live_w[i]) begin
        load_w[i] = 1'b1;
        found_s   = 1'b1;
      end
      nm = nm + int'(expire_w[i]);
    end
    drop_d   = spawn & ~clear & ~found_s;
    h        = int'(health_q) + int'(found_h) - nm;
    health_d = clear ? 4'(HEALTH_INIT) : (h < 0) ? 4'd0 : (h > 15) ? 4'd15 : 4'(h);
  end
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    note_slot #(.LIFE_TICKS(LIFE_TICKS), .TW(TW)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .frame_tick (frame_tick),
      .load_i     (load_w[g]),
      .lane_i     (circletype),
      .hit_i      (hit_w[g]),
      .live_o     (live_w[g]),
      .lane_o     (lane_w[g]),
      .timer_o    (timer_w[g]),
      .expire_o   (expire_w[g])
    );
    assign slot_lane[2*g +: 2] = lane_w[g];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_q    <= 8'd0;
      health_q <= 4'(HEALTH_INIT);
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      oob_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      key_q    <= keycode;
      health_q <= health_d;
      hit_q    <= |hit_w;
      miss_q   <= |expire_w;
      oob_q    <= |hit_w | |expire_w;
      drop_q   <= drop_d;
    end
`ifdef NOTE_TRACKER_SCORE_EN
  logic [15:0] score_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) score_q <= 16'd0;
    else score_q <= clear ? 16'd0 : (|hit_w && score_q != 16'hFFFF) ? score_q + 16'd1 : score_q;
  assign score = score_q;
`endif
  assign hit           = hit_q;
  assign miss          = miss_q;
  assign out_of_bounds = oob_q;
  assign spawn_drop    = drop_q;
  assign health        = health_q;
  assign active        = live_w;
endmodule

// File: tb/tb_note_tracker.sv
// tb_note_tracker: table-driven scoreboard bench plus hand-written corner sequences.
module tb_note_tracker;
  logic       clk = 1'b0;
  logic       rst_n, clear, frame_tick, spawn;
  logic [1:0] circletype;
  logic [7:0] keycode;
  logic       out_of_bounds, hit, miss, spawn_drop;
  logic [3:0] health, active;
  logic [7:0] slot_lane;
`ifdef NOTE_TRACKER_SCORE_EN
  logic [15:0] score;
`endif
  int checks = 0, errors = 0;

  note_tracker #(.NUM_SLOTS(4), .LIFE_TICKS(8), .HIT_WINDOW(3), .HEALTH_INIT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .frame_tick    (frame_tick),
    .spawn         (spawn),
    .circletype    (circletype),
    .keycode       (keycode),
    .out_of_bounds (out_of_bounds),
    .hit           (hit),
    .miss          (miss),
    .health        (health),
    .active        (active),
    .slot_lane     (slot_lane),
    .spawn_drop    (spawn_drop)
`ifdef NOTE_TRACKER_SCORE_EN
    ,
    .score         (score)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, sp;
    logic [1:0] ln;
    logic       tk;
    logic [7:0] key;
    logic       e_hit, e_miss, e_oob, e_drop;
    logic [3:0] e_h, e_act;
  } vec_t;
  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic add(input logic c, s, input logic [1:0] l, input logic t, input logic [7:0] k,
                     input logic eh, em, eo, ed, input logic [3:0] hl, act);
    vec_t v;
    v = '{c, s, l, t, k, eh, em, eo, ed, hl, act};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic step(input logic c, s, input logic [1:0] l, input logic t, input logic [7:0] k);
    clear = c; spawn = s; circletype = l; frame_tick = t; keycode = k;
    @(posedge clk);
    #1;
    clear = 1'b0; spawn = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, keycode);
  endtask

  initial begin
    vec_t e;
    logic seen;
    rst_n = 1'b0; clear = 1'b0; frame_tick = 1'b0; spawn = 1'b0; circletype = 2'd0; keycode = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_health", 0, health, 8);
    chk("reset_active", 0, active, 0);
    chk("reset_lane", 0, slot_lane, 0);
    chk("reset_pulses", 0, {hit, miss, out_of_bounds, spawn_drop}, 0);
    rst_n = 1'b1;

    // single circle expires unhit
    add(0,1,1,0,0, 0,0,0,0, 8,4'b0001);
    for (int i = 0; i < 7; i++) add(0,0,0,1,0, 0,0,0,0, 8,4'b0001);
    add(0,0,0,1,0, 0,1,1,0, 7,4'b0000);
    // press in window hits; press too early is ignored and the circle later misses
    add(0,1,2,0,0, 0,0,0,0, 7,4'b0001);
    for (int i = 0; i < 5; i++) add(0,0,0,1,0, 0,0,0,0, 7,4'b0001);
    add(0,0,0,0,13, 1,0,1,0, 8,4'b0000);
    add(0,0,0,0,0,  0,0,0,0, 8,4'b0000);
    add(0,1,2,0,0,  0,0,0,0, 8,4'b0001);
    for (int i = 0; i < 4; i++) add(0,0,0,1,0, 0,0,0,0, 8,4'b0001);
    add(0,0,0,0,13, 0,0,0,0, 8,4'b0001);
    add(0,0,0,0,0,  0,0,0,0, 8,4'b0001);
    for (int i = 0; i < 3; i++) add(0,0,0,1,0, 0,0,0,0, 8,4'b0001);
    add(0,0,0,1,0, 0,1,1,0, 7,4'b0000);
    // fill all slots, fifth spawn dropped
    add(0,1,0,0,0, 0,0,0,0, 7,4'b0001);
    add(0,1,0,0,0, 0,0,0,0, 7,4'b0011);
    add(0,1,0,0,0, 0,0,0,0, 7,4'b0111);
    add(0,1,0,0,0, 0,0,0,0, 7,4'b1111);
    add(0,1,3,0,0, 0,0,0,1, 7,4'b1111);
    add(0,0,0,0,0, 0,0,0,0, 7,4'b1111);
    add(1,1,0,1,0, 0,0,0,0, 8,4'b0000);
    // held key hits only once, lowest slot first
    add(0,1,0,0,0, 0,0,0,0, 8,4'b0001);
    add(0,1,0,0,0, 0,0,0,0, 8,4'b0011);
    for (int i = 0; i < 5; i++) add(0,0,0,1,0, 0,0,0,0, 8,4'b0011);
    add(0,0,0,0,7, 1,0,1,0, 9,4'b0010);
    add(0,0,0,0,7, 0,0,0,0, 9,4'b0010);
    add(0,0,0,0,7, 0,0,0,0, 9,4'b0010);
    add(0,0,0,0,0, 0,0,0,0, 9,4'b0010);
    // slot retiring by hit is not reused by a same-cycle spawn
    add(1,0,0,0,0, 0,0,0,0, 8,4'b0000);
    add(0,1,0,0,0, 0,0,0,0, 8,4'b0001);
    add(0,1,0,0,0, 0,0,0,0, 8,4'b0011);
    add(0,1,0,0,0, 0,0,0,0, 8,4'b0111);
    add(0,1,0,0,0, 0,0,0,0, 8,4'b1111);
    for (int i = 0; i < 5; i++) add(0,0,0,1,0, 0,0,0,0, 8,4'b1111);
    add(0,1,1,0,7, 1,0,1,1, 9,4'b1110);
    add(0,0,0,0,0, 0,0,0,0, 9,4'b1110);

    for (int i = 0; i < tbl.size(); i++) begin
      exp_q.push_back(tbl[i]);
      step(tbl[i].clr, tbl[i].sp, tbl[i].ln, tbl[i].tk, tbl[i].key);
      e = exp_q.pop_front();
      chk("hit", i, hit, e.e_hit);
      chk("miss", i, miss, e.e_miss);
      chk("out_of_bounds", i, out_of_bounds, e.e_oob);
      chk("spawn_drop", i, spawn_drop, e.e_drop);
      chk("health", i, health, e.e_h);
      chk("active", i, active, e.e_act);
    end

    // simultaneous expiries: one miss pulse, health saturates at 0
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    ticks(8);
    chk("quad_miss", 100, miss, 1);
    chk("quad_health", 100, health, 4);
    step(0, 0, 0, 0, 0);
    chk("quad_miss_once", 101, miss, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    ticks(8);
    chk("tri_health", 102, health, 1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    ticks(8);
    chk("dual_miss", 103, miss, 1);
    chk("dual_health", 103, health, 0);
    step(0, 0, 0, 0, 0);
    chk("dual_miss_once", 104, miss, 0);
    step(0, 1, 1, 0, 0);
    ticks(8);
    chk("floor_miss", 105, miss, 1);
    chk("floor_health", 105, health, 0);

    // press on the expiring tick counts as a hit only; health saturates at 15
    step(1, 0, 0, 0, 0);
    for (int n = 0; n < 8; n++) begin
      step(0, 1, 0, 0, 0);
      ticks(7);
      step(0, 0, 0, 1, 7);
      chk("last_tick_hit", 200 + n, hit, 1);
      chk("last_tick_miss", 200 + n, miss, 0);
      chk("ceil_health", 200 + n, health, (9 + n > 15) ? 15 : 9 + n);
      step(0, 0, 0, 0, 0);
    end

    // async reset mid-game discards live circles silently
    for (int i = 0; i < 3; i++) step(0, 1, 2, 0, 0);
    chk("pre_reset_active", 300, active, 4'b0111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_active", 301, active, 0);
    chk("async_lane", 301, slot_lane, 0);
    chk("async_health", 301, health, 8);
    chk("async_pulses", 301, {hit, miss, out_of_bounds, spawn_drop}, 0);
    #4 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 0);
      seen = seen | miss | out_of_bounds;
    end
    chk("post_reset_quiet", 302, seen, 0);
    chk("post_reset_health", 302, health, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
